periodic_update_gen: RTL and testbench
======================================

Name: periodic_update_gen

Overview:
- Parametrised periodic register updater: `value` is rewritten every PERIOD enabled clock cycles.
- Supports invert, increment, rotate-left and hold modes.
- Supports synchronous load, a per-update strobe and an update counter.
- Clocked successor of the free-running delay-toggle register; used as a stimulus/pattern source in regression benches and small designs.

Parameters:
- WIDTH, 4, bit width of `value` and `load_val` (>=1).
- PERIOD, 10, enabled clock cycles between updates (>=1).
- RESET_VAL, 4'h5, value of `value` after reset (WIDTH bits).
- CNT_W, 8, width of the `upd_count` output (>=1).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance the period prescaler when high.
- mode  input  2  update operation: 00 invert, 01 increment, 10 rotate-left, 11 hold.
- load  input  1  synchronous load of `load_val`.
- load_val  input  WIDTH  value written on load.
- value  output  WIDTH  current register value.
- tick  output  1  one-cycle pulse in the cycle after an update is applied.
- upd_count  output  CNT_W  number of updates since reset, modulo 2^CNT_W.

Behaviour:
- All state changes occur on the rising edge of `clk`.
- Internal prescaler `phase` runs 0..PERIOD-1. Its width is max(1, clog2(PERIOD)).
- Reset (highest priority, any cycle, including mid-period):
  - value=RESET_VAL, phase=0, tick=0, upd_count=0.
- Load (priority below reset):
  - value=load_val, phase=0, tick=0, upd_count unchanged.
  - Load applies regardless of `en`; the period restarts from the load.
- Otherwise, with en=1:
  - If phase==PERIOD-1: an update occurs. phase goes to 0, tick=1 next cycle, upd_count increments and wraps 2^CNT_W-1 -> 0.
  - Otherwise phase increments and tick=0.
- With en=0: phase, value and upd_count hold; tick=0.
- Update operation, with `mode` sampled in the update cycle only:
  - 00: value = ~value.
  - 01: value = value+1, modulo 2^WIDTH (all-ones wraps to 0, no carry out).
  - 10: value = {value[WIDTH-2:0], value[WIDTH-1]}; when WIDTH==1, value is unchanged.
  - 11: value unchanged, but tick and upd_count still fire, so hold keeps period timing.
- Mode changes between updates have no effect until the next update cycle.
- PERIOD==1: an update on every enabled cycle; tick stays high through consecutive enabled cycles.
- Latency: update N is applied at the edge ending the (N*PERIOD)th enabled cycle after reset/load. `value` and `tick` become visible together after that edge.
- Simultaneous load and update cycle: load wins, no update, no tick, no count.
- Simultaneous reset and load: reset wins.
- No X propagation: every register has a defined reset value. After reset, `value` never reads X (contrast the unreset predecessor).

Test Plan:
- Invert baseline:
  - Stimulus: WIDTH=4, PERIOD=10, RESET_VAL=5, mode=00, en=1 from reset release.
  - Response: value=4'h5 for 10 cycles. After 10 enabled edges value=4'hA, tick=1 for one cycle, upd_count=1. After 20 edges value=4'h5, upd_count=2.
- Increment wrap:
  - Stimulus: load load_val=4'hE, mode=01, PERIOD=2.
  - Response: value sequence E,F,0,1 at 2-cycle spacing; no carry artefact at F->0.
- Rotate:
  - Stimulus: load 4'b1001, mode=10, PERIOD=1.
  - Response: value 0011, 0110, 1100, 1001 on successive cycles; tick held high.
- Enable stall and hold mode:
  - Stimulus: drop en for 7 cycles at phase=4.
  - Response: value, phase and upd_count frozen; the update lands exactly 6 enabled cycles after en returns.
  - Stimulus: mode=11.
  - Response: tick still pulses every 10 cycles and value is constant.
- Load/reset collisions:
  - Stimulus: assert load (load_val=4'h3) in the update cycle.
  - Response: value=3, no tick, upd_count unchanged, next update 10 cycles later.
  - Stimulus: assert reset together with load at phase=7.
  - Response: value=4'h5, phase=0, upd_count=0.
- Counter wrap:
  - Stimulus: CNT_W=2, PERIOD=1, 5 updates.
  - Response: upd_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/periodic_update_gen.sv
// periodic_update_gen
//
// Periodic register updater used as a pattern source. `value` is rewritten
// once every PERIOD enabled clock cycles using the operation selected by
// `mode`. A synchronous load restarts the period, and every applied update
// raises `tick` for one cycle and bumps `upd_count`.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (beats load)
//   en         advance the period prescaler
//   mode       00 invert, 01 increment, 10 rotate-left, 11 hold
//   load       synchronous load of load_val, restarts the period
//   load_val   value written on load
//   value      current register value
//   tick       one-cycle pulse after an update has been applied
//   upd_count  updates since reset, wraps modulo 2^CNT_W
module periodic_update_gen #(
  parameter int               WIDTH     = 4,
  parameter int               PERIOD    = 10,
  parameter logic [WIDTH-1:0] RESET_VAL = 4'h5,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             tick,
  output logic [CNT_W-1:0] upd_count
);

  // A one-bit prescaler is kept even for PERIOD==1 so the vector is legal;
  // in that case LAST is 0 and every enabled cycle is an update cycle.
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

  logic [PW-1:0]    phase;
  logic [WIDTH-1:0] rot_val;
  logic [WIDTH-1:0] next_val;

  // Rotation of a single bit is the identity; the slice form would be illegal.
  generate
    if (WIDTH == 1) begin : g_rot1
      assign rot_val = value;
    end else begin : g_rotn
      assign rot_val = {value[WIDTH-2:0], value[WIDTH-1]};
    end
  endgenerate

  // Mode only matters in the update cycle, so it is decoded combinationally
  // and consumed solely when the prescaler wraps.
  always_comb begin
    next_val = value;
    case (mode)
      2'b00:   next_val = ~value;
      2'b01:   next_val = value + WIDTH'(1);
      2'b10:   next_val = rot_val;
      default: next_val = value;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value     <= RESET_VAL;
      phase     <= '0;
      tick      <= 1'b0;
      upd_count <= '0;
    end else if (load) begin
      // Load overrides a coinciding update: no tick, no count.
      value <= load_val;
      phase <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (phase == LAST) begin
        value     <= next_val;
        phase     <= '0;
        tick      <= 1'b1;
        upd_count <= upd_count + CNT_W'(1);
      end else begin
        phase <= phase + PW'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_periodic_update_gen.sv
module tb_periodic_update_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] value10, value2, value1;
  logic       tick10, tick2, tick1;
  logic [7:0] cnt10, cnt2;
  logic [1:0] cnt1;

  int tests_run;
  int tests_failed;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three configurations share all inputs; each test targets one of them.
  periodic_update_gen #(.WIDTH(4), .PERIOD(10), .RESET_VAL(4'h5), .CNT_W(8)) u10 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .value(value10), .tick(tick10), .upd_count(cnt10));

  periodic_update_gen #(.WIDTH(4), .PERIOD(2), .RESET_VAL(4'h5), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .value(value2), .tick(tick2), .upd_count(cnt2));

  periodic_update_gen #(.WIDTH(4), .PERIOD(1), .RESET_VAL(4'h5), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .value(value1), .tick(tick1), .upd_count(cnt1));

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 4'h0;
    do_reset();
    tests_run++;
    if (value10 !== 4'h5) begin $display("FAIL reset_value10 got=%h exp=5", value10); tests_failed++; end
    tests_run++;
    if (tick10 !== 1'b0) begin $display("FAIL reset_tick10 got=%b exp=0", tick10); tests_failed++; end
    tests_run++;
    if (cnt10 !== 8'd0) begin $display("FAIL reset_cnt10 got=%0d exp=0", cnt10); tests_failed++; end
    tests_run++;
    if (value1 !== 4'h5 || cnt1 !== 2'd0 || tick1 !== 1'b0) begin
      $display("FAIL reset_u1 got=%h/%0d/%b exp=5/0/0", value1, cnt1, tick1); tests_failed++;
    end
  endtask

  task automatic test_invert();
    logic [3:0] exp_v;
    logic       exp_t;
    logic [7:0] exp_c;
    do_reset();
    en = 1'b1; mode = 2'b00;
    for (int i = 1; i <= 21; i++) begin
      cyc();
      exp_v = (i >= 10 && i < 20) ? 4'hA : 4'h5;
      exp_t = (i == 10 || i == 20);
      exp_c = 8'(i / 10);
      tests_run++;
      if (value10 !== exp_v || tick10 !== exp_t || cnt10 !== exp_c) begin
        $display("FAIL invert edge=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                 i, value10, tick10, cnt10, exp_v, exp_t, exp_c);
        tests_failed++;
      end
    end
  endtask

  task automatic test_inc_wrap();
    logic [3:0] exp_v;
    logic       exp_t;
    en = 1'b1; mode = 2'b01; load = 1'b1; load_val = 4'hE;
    cyc();
    load = 1'b0;
    tests_run++;
    if (value2 !== 4'hE || tick2 !== 1'b0) begin
      $display("FAIL inc_load got=%h/%b exp=e/0", value2, tick2); tests_failed++;
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      exp_v = 4'(4'hE + (k / 2));
      exp_t = (k % 2 == 0);
      tests_run++;
      if (value2 !== exp_v || tick2 !== exp_t) begin
        $display("FAIL inc_wrap edge=%0d got=%h/%b exp=%h/%b", k, value2, tick2, exp_v, exp_t);
        tests_failed++;
      end
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0011; exp_seq[1] = 4'b0110; exp_seq[2] = 4'b1100; exp_seq[3] = 4'b1001;
    en = 1'b1; mode = 2'b10; load = 1'b1; load_val = 4'b1001;
    cyc();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      tests_run++;
      if (value1 !== exp_seq[k] || tick1 !== 1'b1) begin
        $display("FAIL rotate step=%0d got=%b/%b exp=%b/1", k, value1, tick1, exp_seq[k]);
        tests_failed++;
      end
    end
  endtask

  // Leaves u10 at phase 0, value A, count 1.
  task automatic test_stall();
    do_reset();
    en = 1'b1; mode = 2'b00;
    repeat (4) cyc();
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      tests_run++;
      if (value10 !== 4'h5 || tick10 !== 1'b0 || cnt10 !== 8'd0) begin
        $display("FAIL stall_frozen k=%0d got=%h/%b/%0d exp=5/0/0", k, value10, tick10, cnt10);
        tests_failed++;
      end
    end
    en = 1'b1;
    repeat (5) cyc();
    tests_run++;
    if (value10 !== 4'h5 || tick10 !== 1'b0) begin
      $display("FAIL stall_early got=%h/%b exp=5/0", value10, tick10); tests_failed++;
    end
    cyc();
    tests_run++;
    if (value10 !== 4'hA || tick10 !== 1'b1 || cnt10 !== 8'd1) begin
      $display("FAIL stall_update got=%h/%b/%0d exp=a/1/1", value10, tick10, cnt10); tests_failed++;
    end
  endtask

  // Mode is invert for most of the period but hold in the update cycle.
  task automatic test_hold();
    en = 1'b1; mode = 2'b00;
    repeat (9) cyc();
    tests_run++;
    if (value10 !== 4'hA || tick10 !== 1'b0) begin
      $display("FAIL hold_mid got=%h/%b exp=a/0", value10, tick10); tests_failed++;
    end
    mode = 2'b11;
    cyc();
    tests_run++;
    if (value10 !== 4'hA || tick10 !== 1'b1 || cnt10 !== 8'd2) begin
      $display("FAIL hold_update got=%h/%b/%0d exp=a/1/2", value10, tick10, cnt10); tests_failed++;
    end
    mode = 2'b00;
  endtask

  task automatic test_load_collide();
    en = 1'b1; mode = 2'b00;
    repeat (9) cyc();
    load = 1'b1; load_val = 4'h3;
    cyc();
    load = 1'b0;
    tests_run++;
    if (value10 !== 4'h3 || tick10 !== 1'b0 || cnt10 !== 8'd2) begin
      $display("FAIL load_collide got=%h/%b/%0d exp=3/0/2", value10, tick10, cnt10); tests_failed++;
    end
    repeat (9) cyc();
    tests_run++;
    if (value10 !== 4'h3 || tick10 !== 1'b0) begin
      $display("FAIL load_restart_early got=%h/%b exp=3/0", value10, tick10); tests_failed++;
    end
    cyc();
    tests_run++;
    if (value10 !== 4'hC || tick10 !== 1'b1 || cnt10 !== 8'd3) begin
      $display("FAIL load_restart_update got=%h/%b/%0d exp=c/1/3", value10, tick10, cnt10); tests_failed++;
    end
  endtask

  task automatic test_reset_load();
    en = 1'b1; mode = 2'b00;
    repeat (7) cyc();
    reset = 1'b1; load = 1'b1; load_val = 4'h3;
    cyc();
    reset = 1'b0; load = 1'b0;
    tests_run++;
    if (value10 !== 4'h5 || tick10 !== 1'b0 || cnt10 !== 8'd0) begin
      $display("FAIL reset_load got=%h/%b/%0d exp=5/0/0", value10, tick10, cnt10); tests_failed++;
    end
    repeat (9) cyc();
    tests_run++;
    if (value10 !== 4'h5) begin
      $display("FAIL reset_load_phase_early got=%h exp=5", value10); tests_failed++;
    end
    cyc();
    tests_run++;
    if (value10 !== 4'hA || tick10 !== 1'b1 || cnt10 !== 8'd1) begin
      $display("FAIL reset_load_phase_update got=%h/%b/%0d exp=a/1/1", value10, tick10, cnt10); tests_failed++;
    end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] exp_c [5];
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd0; exp_c[4] = 2'd1;
    en = 1'b0; mode = 2'b11;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      tests_run++;
      if (cnt1 !== exp_c[k] || tick1 !== 1'b1 || value1 !== 4'h5) begin
        $display("FAIL cnt_wrap step=%0d got=%0d/%b/%h exp=%0d/1/5", k, cnt1, tick1, value1, exp_c[k]);
        tests_failed++;
      end
    end
    en = 1'b0;
    cyc();
    tests_run++;
    if (tick1 !== 1'b0 || cnt1 !== 2'd1) begin
      $display("FAIL cnt_wrap_idle got=%b/%0d exp=0/1", tick1, cnt1); tests_failed++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 4'h0;
    cyc();
    test_reset();
    test_invert();
    test_inc_wrap();
    test_rotate();
    test_stall();
    test_hold();
    test_load_collide();
    test_reset_load();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
